fifo_wr_ctrl: RTL and testbench

- Write-side controller of the async FIFO, living entirely in the write clock domain.
- Owns the write pointer (binary and Gray) and the write handshake to the producer.
- Drives write-enable/address to the dual-port FIFO memory.
- Computes full, almost_full, fill level and a sticky overflow flag from the read pointer after it has been synchronized into the write domain.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_wr_ctrl.sv | 69 ++++++
 tb/tb_fifo_wr_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer helpers and sizing for the async FIFO controllers
package fifo_pkg;

  localparam int ADDR_WIDTH_DFLT = 4;
  localparam int DEPTH           = 1 << ADDR_WIDTH_DFLT;

  // Helpers work on a wide container; zero-extending a narrower pointer keeps the low bits exact.
  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side controller: pointers, handshake, full/level/overflow
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DFLT,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_gray;
  logic          accept;

  assign wr_ready  = ~full & wrst_n;
  assign accept    = wr_valid & wr_ready;
  assign mem_we    = accept;
  assign mem_waddr = wbin[ADDR_WIDTH-1:0];

  // Flags are computed from the post-write pointer so full is never a cycle late.
  always_comb begin
    wbin_next  = wbin + PW'(accept);
    wgray_next = PW'(bin2gray(ptr_max_t'(wbin_next)));
    rbin       = PW'(gray2bin(ptr_max_t'(rptr_gray_sync)));
    level_next = wbin_next - rbin;
    full_gray  = {~rptr_gray_sync[ADDR_WIDTH -: 2], rptr_gray_sync[ADDR_WIDTH-2:0]};
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= (wgray_next == full_gray);
      almost_full <= (level_next >= PW'(AFULL_THRESH));
      wr_level    <= level_next;
      if (wr_valid && full) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl against a counting model
module tb_fifo_wr_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [4:0] wptr_gray;
  logic [4:0] rptr_gray_sync;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  int rcnt = 0;
  int checks = 0;
  int errors = 0;

  assign rptr_gray_sync = 5'((rcnt & 31) ^ ((rcnt & 31) >> 1));

  fifo_wr_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .wptr_gray(wptr_gray),
    .rptr_gray_sync(rptr_gray_sync), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 wclk = ~wclk;

  // Model: count accepted writes and derive level from the distance to the read count.
  int m_wcnt = 0, m_lvl = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0, m_valid = 0;

  always @(posedge wclk) begin
    if (!wrst_n) begin
      m_wcnt = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0; m_valid = 1;
    end else begin
      if (wr_valid && m_full) m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
      if (wr_valid && !m_full) m_wcnt = (m_wcnt + 1) & 31;
      m_lvl  = (m_wcnt - rcnt) & 31;
      m_full = (m_lvl == 16);
      m_af   = (m_lvl >= 12);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge wclk) begin
    if (m_valid) begin
      chk("m_ready", int'(wr_ready), int'(wrst_n && !m_full));
      chk("m_we", int'(mem_we), int'(wrst_n && !m_full && wr_valid));
      chk("m_waddr", int'(mem_waddr), m_wcnt & 15);
      chk("m_gray", int'(wptr_gray), m_wcnt ^ (m_wcnt >> 1));
      chk("m_full", int'(full), int'(m_full));
      chk("m_afull", int'(almost_full), int'(m_af));
      chk("m_level", int'(wr_level), m_lvl);
      chk("m_ovf", int'(overflow), int'(m_ovf));
    end
  end

  task automatic tick(input bit v, input bit c, input bit r, input int rc);
    wr_valid = v; overflow_clr = c; wrst_n = r; rcnt = rc;
    @(posedge wclk);
    #2;
  endtask

  initial begin
    // Reset held with a write offered
    repeat (3) tick(1, 0, 0, 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_ready", int'(wr_ready), 0);
    chk("rst_gray", int'(wptr_gray), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(wr_level), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Fill 16 back-to-back
    for (int i = 0; i < 16; i++) begin
      chk("fill_waddr", int'(mem_waddr), i);
      tick(1, 0, 1, 0);
      if (i == 10) chk("afull_11", int'(almost_full), 0);
      if (i == 11) chk("afull_12", int'(almost_full), 1);
      if (i == 14) chk("full_15", int'(full), 0);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(wr_level), 16);
    chk("fill_gray", int'(wptr_gray), 5'b11000);
    chk("full_we", int'(mem_we), 0);

    // Overflow set / clear / set-wins
    tick(1, 0, 1, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_level", int'(wr_level), 16);
    tick(0, 1, 1, 0);
    chk("ovf_clr", int'(overflow), 0);
    tick(1, 1, 1, 0);
    chk("ovf_setwins", int'(overflow), 1);
    tick(0, 1, 1, 0);
    chk("ovf_clr2", int'(overflow), 0);

    // Drain to read count 4
    tick(0, 0, 1, 4);
    chk("drain_full", int'(full), 0);
    chk("drain_level", int'(wr_level), 12);
    chk("drain_afull", int'(almost_full), 1);
    chk("drain_ready", int'(wr_ready), 1);

    // Wrap: bring wbin to 31 with read count 16, then one more write
    tick(0, 0, 1, 16);
    for (int i = 0; i < 15; i++) tick(1, 0, 1, 16);
    chk("wrap_level15", int'(wr_level), 15);
    chk("wrap_waddr", int'(mem_waddr), 15);
    tick(1, 0, 1, 16);
    chk("wrap_gray", int'(wptr_gray), 0);
    chk("wrap_full", int'(full), 1);
    chk("wrap_level16", int'(wr_level), 16);

    // Write and read advance together while full: write rejected
    tick(1, 0, 1, 20);
    chk("rdadv_full", int'(full), 0);
    chk("rdadv_level", int'(wr_level), 12);
    chk("rdadv_waddr", int'(mem_waddr), 0);

    // Mid-operation reset at wbin=7
    tick(0, 0, 1, 32);
    for (int i = 0; i < 7; i++) tick(1, 0, 1, 32);
    chk("pre_rst_waddr", int'(mem_waddr), 7);
    tick(1, 0, 0, 32);
    chk("midrst_gray", int'(wptr_gray), 0);
    chk("midrst_waddr", int'(mem_waddr), 0);
    chk("midrst_level", int'(wr_level), 0);
    tick(1, 0, 1, 32);
    chk("post_rst_waddr", int'(mem_waddr), 1);
    chk("post_rst_level", int'(wr_level), 1);
    tick(0, 0, 1, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
